// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read side of the dual-clock FIFO, entirely in the rclk domain.
//   - Brings the Gray write pointer across with a two-flop synchroniser and
//     converts it back to binary to compute occupancy.
//   - Pops fifo_mem (combinational read at b_rptr) into a registered
//     valid/ready output stage.
//   - Publishes a registered Gray read pointer for the write-side full logic.
// Ports:
//   rclk, rrst          clock and synchronous active-high reset
//   g_wptr              Gray write pointer from the wclk domain (unsynchronised)
//   fifo_rdata          fifo_mem read data at b_rptr
//   m_ready             downstream accepts m_data this cycle
//   b_rptr / g_rptr     binary read pointer to memory / Gray read pointer out
//   r_en                pop strobe (combinational)
//   empty               registered empty flag
//   almost_empty        rd_count <= AE_THRESH
//   rd_count            words in memory, not counting the one held in m_data
//   m_valid / m_data    registered output stage
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PTR_WIDTH  = 3,
    parameter int AE_THRESH  = 2
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic [PTR_WIDTH:0]    g_wptr,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    input  logic                  m_ready,
    output logic [PTR_WIDTH:0]    b_rptr,
    output logic [PTR_WIDTH:0]    g_rptr,
    output logic                  r_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    rd_count,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data
);

    localparam logic [PTR_WIDTH:0] AE_LIMIT = (PTR_WIDTH + 1)'(AE_THRESH);

    logic [PTR_WIDTH:0]    wq1_q, wq1_d;
    logic [PTR_WIDTH:0]    wq2_q, wq2_d;
    logic [PTR_WIDTH:0]    b_rptr_q, b_rptr_d;
    logic [PTR_WIDTH:0]    g_rptr_q, g_rptr_d;
    logic                  empty_q, empty_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;

    logic [PTR_WIDTH:0]    wbin;
    logic [PTR_WIDTH:0]    b_next;
    logic [PTR_WIDTH:0]    g_next;
    logic                  pop;

    // Gray to binary: each binary bit is the XOR of all Gray bits at and above it.
    // Written as a reduction per bit to avoid a self-referencing vector.
    generate
        for (genvar gi = 0; gi <= PTR_WIDTH; gi++) begin : g_gray2bin
            assign wbin[gi] = ^wq2_q[PTR_WIDTH:gi];
        end
    endgenerate

    always_comb begin
        // Pop whenever memory has data and the output stage is free or draining.
        pop       = !empty_q && (!m_valid_q || m_ready);
        b_next    = b_rptr_q + {{PTR_WIDTH{1'b0}}, pop};
        g_next    = b_next ^ (b_next >> 1);

        wq1_d     = g_wptr;
        wq2_d     = wq1_q;
        b_rptr_d  = b_next;
        g_rptr_d  = g_next;
        // Compare the post-pop pointer so popping the last entry raises empty
        // on the same edge.
        empty_d   = (g_next == wq2_q);

        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (pop) begin
            m_valid_d = 1'b1;
            m_data_d  = fifo_rdata;
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            wq1_q     <= '0;
            wq2_q     <= '0;
            b_rptr_q  <= '0;
            g_rptr_q  <= '0;
            empty_q   <= 1'b1;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            wq1_q     <= wq1_d;
            wq2_q     <= wq2_d;
            b_rptr_q  <= b_rptr_d;
            g_rptr_q  <= g_rptr_d;
            empty_q   <= empty_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    // Modulo subtraction; the extra pointer bit lets a full memory read DEPTH.
    assign rd_count     = wbin - b_rptr_q;
    assign almost_empty = (rd_count <= AE_LIMIT);

    assign b_rptr  = b_rptr_q;
    assign g_rptr  = g_rptr_q;
    assign r_en    = pop;
    assign empty   = empty_q;
    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural fifo_mem and write side.
module tb_fifo_rd_ctrl;

    logic       clk = 1'b0;
    logic       rrst;
    logic [3:0] g_wptr;
    logic [7:0] fifo_rdata;
    logic       m_ready;
    logic [3:0] b_rptr;
    logic [3:0] g_rptr;
    logic       r_en;
    logic       empty;
    logic       almost_empty;
    logic [3:0] rd_count;
    logic       m_valid;
    logic [7:0] m_data;

    logic [7:0] mem [8];
    logic [3:0] wptr;
    int         pass_cnt = 0;
    int         total_cnt = 0;

    always #5 clk = ~clk;

    assign fifo_rdata = mem[b_rptr[2:0]];

    fifo_rd_ctrl #(.DATA_WIDTH(8), .PTR_WIDTH(3), .AE_THRESH(2)) dut (
        .rclk(clk), .rrst(rrst), .g_wptr(g_wptr), .fifo_rdata(fifo_rdata),
        .m_ready(m_ready), .b_rptr(b_rptr), .g_rptr(g_rptr), .r_en(r_en),
        .empty(empty), .almost_empty(almost_empty), .rd_count(rd_count),
        .m_valid(m_valid), .m_data(m_data)
    );

    function automatic logic [3:0] gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] d);
        mem[wptr[2:0]] = d;
        wptr           = wptr + 4'd1;
        g_wptr         = gray(wptr);
    endtask

    initial begin
        logic [7:0] exp_q [$];
        logic [7:0] exp_word;
        logic [7:0] held_data;
        logic       hold_pending;
        logic [3:0] prev_b, prev_g, occ;
        logic       saw_bwrap, saw_gwrap;
        int         written, received, cyc;

        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        rrst = 1'b1; wptr = 4'd0; g_wptr = 4'd0; m_ready = 1'b0;

        // 1. reset
        step(); step();
        check("rst_empty",   32'(empty), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_b_rptr",  32'(b_rptr), 32'd0);
        check("rst_g_rptr",  32'(g_rptr), 32'd0);
        check("rst_rd_count",32'(rd_count), 32'd0);
        check("rst_ae",      32'(almost_empty), 32'd1);
        $display("reset: empty=%0b m_valid=%0b rd_count=%0d", empty, m_valid, rd_count);
        rrst = 1'b0;

        // 2. single word, latency
        m_ready = 1'b1;
        write_word(8'hA5);
        step(); step();
        check("lat_e2_empty", 32'(empty), 32'd1);
        step();
        check("lat_e3_empty", 32'(empty), 32'd0);
        check("lat_e3_r_en",  32'(r_en), 32'd1);
        check("lat_e3_count", 32'(rd_count), 32'd1);
        check("lat_e3_valid", 32'(m_valid), 32'd0);
        step();
        check("lat_e4_valid", 32'(m_valid), 32'd1);
        check("lat_e4_data",  32'(m_data), 32'hA5);
        check("lat_e4_b_rptr",32'(b_rptr), 32'd1);
        check("lat_e4_g_rptr",32'(g_rptr), 32'd1);
        check("lat_e4_empty", 32'(empty), 32'd1);
        $display("single: m_data=%0h b_rptr=%0d empty=%0b", m_data, b_rptr, empty);

        // 3. backpressure with three more words
        m_ready = 1'b0;
        write_word(8'h11); write_word(8'h22); write_word(8'h33);
        step(); step(); step();
        check("bp_rd_count", 32'(rd_count), 32'd3);
        check("bp_b_rptr",   32'(b_rptr), 32'd1);
        check("bp_valid",    32'(m_valid), 32'd1);
        check("bp_data",     32'(m_data), 32'hA5);
        check("bp_r_en",     32'(r_en), 32'd0);
        check("bp_empty",    32'(empty), 32'd0);
        check("bp_ae",       32'(almost_empty), 32'd0);
        step(); step();
        check("bp_data_hold",32'(m_data), 32'hA5);
        check("bp_count_hold",32'(rd_count), 32'd3);
        $display("backpressure: m_data=%0h rd_count=%0d", m_data, rd_count);

        // 4. stream 20 words, random m_ready
        exp_q = '{8'hA5, 8'h11, 8'h22, 8'h33};
        written = 0; received = 0; cyc = 0;
        saw_bwrap = 1'b0; saw_gwrap = 1'b0; hold_pending = 1'b0;
        prev_b = b_rptr; prev_g = g_rptr; held_data = 8'h00;
        while (received < 24 && cyc < 500) begin
            if (prev_b == 4'hF && b_rptr == 4'h0) saw_bwrap = 1'b1;
            if (prev_g == 4'b1000 && g_rptr == 4'b0000) saw_gwrap = 1'b1;
            prev_b = b_rptr; prev_g = g_rptr;
            check("str_gray", 32'(g_rptr), 32'(gray(b_rptr)));
            if (hold_pending) begin
                check("str_hold_valid", 32'(m_valid), 32'd1);
                check("str_hold_data",  32'(m_data), 32'(held_data));
            end
            m_ready = 1'($urandom_range(0, 1));
            hold_pending = m_valid && !m_ready;
            held_data    = m_data;
            if (m_valid && m_ready) begin
                exp_word = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                check("str_data", 32'(m_data), 32'(exp_word));
                $display("stream: word %0d m_data=%0h expected=%0h", received, m_data, exp_word);
                received++;
            end
            occ = wptr - b_rptr;
            if (written < 20 && occ < 4'd8) begin
                write_word(8'h40 + 8'(written));
                exp_q.push_back(8'h40 + 8'(written));
                written++;
            end
            step();
            cyc++;
        end
        check("str_received", 32'(received), 32'd24);
        check("str_bwrap",    32'(saw_bwrap), 32'd1);
        check("str_gwrap",    32'(saw_gwrap), 32'd1);
        m_ready = 1'b0;
        step(); step();
        check("str_end_b_rptr", 32'(b_rptr), 32'd8);
        check("str_end_empty",  32'(empty), 32'd1);
        check("str_end_valid",  32'(m_valid), 32'd0);
        check("str_end_count",  32'(rd_count), 32'd0);
        $display("stream end: b_rptr=%0d received=%0d", b_rptr, received);

        // 5. full memory, almost_empty boundary
        rrst = 1'b1; wptr = 4'd0; g_wptr = 4'd0;
        step(); step();
        rrst = 1'b0;
        for (int i = 0; i < 8; i++) write_word(8'h80 + 8'(i));
        check("full_g_wptr", 32'(g_wptr), 32'b1100);
        step(); step();
        check("full_count8", 32'(rd_count), 32'd8);
        check("full_ae8",    32'(almost_empty), 32'd0);
        step(); step();
        check("full_count7", 32'(rd_count), 32'd7);
        check("full_data0",  32'(m_data), 32'h80);
        step();
        check("full_stall_count", 32'(rd_count), 32'd7);
        check("full_stall_b_rptr",32'(b_rptr), 32'd1);
        check("full_ae7",    32'(almost_empty), 32'd0);
        m_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check("drain_data", 32'(m_data), 32'(8'h80 + 8'(k)));
            $display("drain: m_data=%0h rd_count=%0d almost_empty=%0b", m_data, rd_count, almost_empty);
            if (k == 4) begin
                check("drain_count3", 32'(rd_count), 32'd3);
                check("drain_ae3",    32'(almost_empty), 32'd0);
            end
        end
        check("drain_count2", 32'(rd_count), 32'd2);
        check("drain_ae2",    32'(almost_empty), 32'd1);
        m_ready = 1'b0;

        // 6. reset mid-stream with rd_count=5
        write_word(8'hC0); write_word(8'hC1); write_word(8'hC2);
        step(); step();
        check("mid_count5", 32'(rd_count), 32'd5);
        check("mid_valid",  32'(m_valid), 32'd1);
        rrst = 1'b1; wptr = 4'd0; g_wptr = 4'd0;
        step();
        check("mid_rst_valid",  32'(m_valid), 32'd0);
        check("mid_rst_b_rptr", 32'(b_rptr), 32'd0);
        check("mid_rst_g_rptr", 32'(g_rptr), 32'd0);
        check("mid_rst_empty",  32'(empty), 32'd1);
        check("mid_rst_data",   32'(m_data), 32'd0);
        check("mid_rst_count",  32'(rd_count), 32'd0);
        $display("mid reset: m_valid=%0b b_rptr=%0d empty=%0b", m_valid, b_rptr, empty);
        rrst = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
